// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_pkg
// Description : Shared widths, ALU-op encodings, zero-register index and
//               bubble control vector for the ID/EX pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_stage_pkg;

    localparam int C_DATA_W  = 32;
    localparam int C_REG_AW  = 5;
    localparam int C_ALUOP_W = 4;

    // ALU operation encodings carried on ex_alu_op
    localparam logic [C_ALUOP_W-1:0] C_ALU_ADD = 4'd0;
    localparam logic [C_ALUOP_W-1:0] C_ALU_SUB = 4'd1;
    localparam logic [C_ALUOP_W-1:0] C_ALU_AND = 4'd2;
    localparam logic [C_ALUOP_W-1:0] C_ALU_OR  = 4'd3;
    localparam logic [C_ALUOP_W-1:0] C_ALU_XOR = 4'd4;
    localparam logic [C_ALUOP_W-1:0] C_ALU_SLT = 4'd5;
    localparam logic [C_ALUOP_W-1:0] C_ALU_SLL = 4'd6;
    localparam logic [C_ALUOP_W-1:0] C_ALU_SRL = 4'd7;
    localparam logic [C_ALUOP_W-1:0] C_ALU_SRA = 4'd8;

    // Register x0 is hard-wired to zero, so it never forwards or hazards
    localparam logic [C_REG_AW-1:0] C_ZERO_REG = '0;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    // A bubble must never write a register or memory
    localparam ctrl_t C_BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/id_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_detect
// Description : Combinational load-use hazard detection for the ID/EX stage.
//               A flush suppresses the stall since the ID instruction is dead.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = C_REG_AW
) (
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic              i_ex_valid,
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_flush,
    output logic              o_haz,
    output logic              o_stall
);

    localparam logic [REG_AW-1:0] c_zero = REG_AW'(C_ZERO_REG);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        w_rs1_hit = i_id_use_rs1 && (i_ex_rd == i_id_rs1);
        w_rs2_hit = i_id_use_rs2 && (i_ex_rd == i_id_rs2);
        o_haz     = i_id_valid && i_ex_valid && i_ex_mem_read &&
                    (i_ex_rd != c_zero) && (w_rs1_hit || w_rs2_hit);
        o_stall   = o_haz && !i_flush;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with write-back bypass into the
//               register-file operands, load-use stall/bubble insertion,
//               branch flush and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W  = C_DATA_W,
    parameter int REG_AW  = C_REG_AW,
    parameter int ALUOP_W = C_ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [DATA_W-1:0]  id_rdata1,
    input  logic [DATA_W-1:0]  id_rdata2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_alu_src,
    input  logic               id_branch,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               wb_reg_write,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               stall,
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_op1,
    output logic [DATA_W-1:0]  ex_op2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [REG_AW-1:0] c_zero = REG_AW'(C_ZERO_REG);

    logic               w_haz;
    logic               w_stall;
    logic [DATA_W-1:0]  w_op1;
    logic [DATA_W-1:0]  w_op2;
    ctrl_t              w_id_ctrl;

    logic               r_valid;
    logic [REG_AW-1:0]  r_rs1;
    logic [REG_AW-1:0]  r_rs2;
    logic [REG_AW-1:0]  r_rd;
    logic [DATA_W-1:0]  r_op1;
    logic [DATA_W-1:0]  r_op2;
    logic [DATA_W-1:0]  r_imm;
    ctrl_t              r_ctrl;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [CNT_W-1:0]   r_cnt;

    id_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_use_rs1  (id_use_rs1),
        .i_id_use_rs2  (id_use_rs2),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .i_flush       (flush),
        .o_haz         (w_haz),
        .o_stall       (w_stall)
    );

    // Register file has no write-through, so forward a same-cycle write-back
    always_comb begin
        w_op1 = id_rdata1;
        w_op2 = id_rdata2;
        if (wb_reg_write && (wb_rd != c_zero) && (wb_rd == id_rs1)) begin
            w_op1 = wb_data;
        end
        if (wb_reg_write && (wb_rd != c_zero) && (wb_rd == id_rs2)) begin
            w_op2 = wb_data;
        end
    end

    // Gather the decoded control bits into one vector
    always_comb begin
        w_id_ctrl            = C_BUBBLE_CTRL;
        w_id_ctrl.reg_write  = id_reg_write;
        w_id_ctrl.mem_read   = id_mem_read;
        w_id_ctrl.mem_write  = id_mem_write;
        w_id_ctrl.mem_to_reg = id_mem_to_reg;
        w_id_ctrl.alu_src    = id_alu_src;
        w_id_ctrl.branch     = id_branch;
    end

    // Pipeline register: flush or hazard loads a bubble, else take ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_imm    <= '0;
            r_ctrl   <= C_BUBBLE_CTRL;
            r_alu_op <= '0;
        end else if (flush || w_haz) begin
            r_valid  <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_imm    <= '0;
            r_ctrl   <= C_BUBBLE_CTRL;
            r_alu_op <= '0;
        end else begin
            r_valid  <= id_valid;
            r_rs1    <= id_rs1;
            r_rs2    <= id_rs2;
            r_rd     <= id_rd;
            r_op1    <= w_op1;
            r_op2    <= w_op2;
            r_imm    <= id_imm;
            r_ctrl   <= id_valid ? w_id_ctrl : C_BUBBLE_CTRL;
            r_alu_op <= id_valid ? id_alu_op : '0;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign stall         = w_stall;
    assign ex_valid      = r_valid;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_op1        = r_op1;
    assign ex_op2        = r_op2;
    assign ex_imm        = r_imm;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_branch     = r_ctrl.branch;
    assign ex_alu_op     = r_alu_op;
    assign stall_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: directed vector table,
//               reset/saturation sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
    logic [3:0]  id_alu_op;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        stall, ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
    logic [3:0]  ex_alu_op;
    logic [3:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_alu_op(ex_alu_op), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the EX-side state ----------------
    typedef struct {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] op1, op2, imm;
        logic        rw, mr, mw, m2r, as, br;
        logic [3:0]  alu;
    } ex_t;

    ex_t m;
    int  m_cnt;

    task automatic model_reset();
        m = '{valid: 0, rs1: 0, rs2: 0, rd: 0, op1: 0, op2: 0, imm: 0,
              rw: 0, mr: 0, mw: 0, m2r: 0, as: 0, br: 0, alu: 0};
        m_cnt = 0;
    endtask

    function automatic logic m_haz();
        logic hit;
        hit = (id_use_rs1 && m.rd == id_rs1) || (id_use_rs2 && m.rd == id_rs2);
        return id_valid && m.valid && m.mr && (m.rd != 0) && hit;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        return (wb_reg_write && wb_rd != 0 && wb_rd == rs) ? wb_data : rf;
    endfunction

    // Next EX contents given the current ID/WB inputs
    task automatic model_edge();
        ex_t n;
        logic h;
        h = m_haz();
        if (h && !flush) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        if (flush || h) begin
            n = '{valid: 0, rs1: 0, rs2: 0, rd: 0, op1: 0, op2: 0, imm: 0,
                  rw: 0, mr: 0, mw: 0, m2r: 0, as: 0, br: 0, alu: 0};
        end else begin
            n.valid = id_valid;
            n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.imm = id_imm;
            n.op1 = fwd(id_rs1, id_rdata1);
            n.op2 = fwd(id_rs2, id_rdata2);
            n.rw  = id_valid & id_reg_write;  n.mr = id_valid & id_mem_read;
            n.mw  = id_valid & id_mem_write;  n.m2r = id_valid & id_mem_to_reg;
            n.as  = id_valid & id_alu_src;    n.br = id_valid & id_branch;
            n.alu = id_valid ? id_alu_op : 4'd0;
        end
        m = n;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
        chk({tag, ".rd"},    {27'd0, ex_rd},    {27'd0, m.rd});
        chk({tag, ".op1"},   ex_op1, m.op1);
        chk({tag, ".op2"},   ex_op2, m.op2);
        chk({tag, ".ctrl"},
            {26'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch},
            {26'd0, m.rw, m.mr, m.mw, m.m2r, m.as, m.br});
        chk({tag, ".cnt"},   {28'd0, stall_cnt}, m_cnt);
        if (m.valid) begin
            chk({tag, ".idx"}, {22'd0, ex_rs1, ex_rs2}, {22'd0, m.rs1, m.rs2});
            chk({tag, ".imm"}, ex_imm, m.imm);
            chk({tag, ".alu"}, {28'd0, ex_alu_op}, {28'd0, m.alu});
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_alu_src = 0; id_branch = 0; id_alu_op = 0;
        wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v; logic [4:0] rs1, rs2, rd; logic u1, u2; logic [31:0] rd1, rd2; logic mr;
        logic wbw; logic [4:0] wbrd; logic [31:0] wbd; logic fl;
        logic e_stall, e_valid; logic [31:0] e_op1, e_op2; logic [4:0] e_rd; logic e_mr;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic u1, input logic u2, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic mr, input logic wbw,
                                input int wbrd, input logic [31:0] wbd, input logic fl,
                                input logic es, input logic ev, input logic [31:0] eo1,
                                input logic [31:0] eo2, input int erd, input logic emr,
                                input int ecnt);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd); r.u1 = u1; r.u2 = u2;
        r.rd1 = rd1; r.rd2 = rd2; r.mr = mr; r.wbw = wbw; r.wbrd = 5'(wbrd); r.wbd = wbd;
        r.fl = fl; r.e_stall = es; r.e_valid = ev; r.e_op1 = eo1; r.e_op2 = eo2;
        r.e_rd = 5'(erd); r.e_mr = emr; r.e_cnt = 4'(ecnt);
        return r;
    endfunction

    task automatic drive_vec(input vec_t x);
        id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
        id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_rdata1 = x.rd1; id_rdata2 = x.rd2;
        id_mem_read = x.mr; id_mem_to_reg = x.mr; id_reg_write = x.v;
        id_imm = 32'h100; id_alu_op = 4'd2;
        wb_reg_write = x.wbw; wb_rd = x.wbrd; wb_data = x.wbd; flush = x.fl;
    endtask

    initial begin
        //            v rs1 rs2 rd u1 u2 rdata1 rdata2 mr wbw wbrd wbdata   fl | st v op1 op2 rd mr cnt
        vt[0]  = mk(1, 5, 6, 3, 1, 1, 32'h11, 32'h22, 0, 1, 5, 32'hDEAD, 0, 0, 1, 32'hDEAD, 32'h22, 3, 0, 0);
        vt[1]  = mk(1, 0, 6, 4, 1, 1, 32'h11, 32'h22, 0, 1, 0, 32'hDEAD, 0, 0, 1, 32'h11, 32'h22, 4, 0, 0);
        vt[2]  = mk(1, 9, 9, 7, 1, 1, 32'h1, 32'h2, 1, 1, 9, 32'hBEEF, 0, 0, 1, 32'hBEEF, 32'hBEEF, 7, 1, 0);
        vt[3]  = mk(1, 1, 7, 8, 0, 1, 32'h33, 32'h44, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1);
        vt[4]  = mk(1, 1, 7, 8, 0, 1, 32'h33, 32'h44, 0, 0, 0, 32'h0, 0, 0, 1, 32'h33, 32'h44, 8, 0, 1);
        vt[5]  = mk(1, 2, 3, 7, 1, 1, 32'h55, 32'h66, 1, 0, 0, 32'h0, 0, 0, 1, 32'h55, 32'h66, 7, 1, 1);
        vt[6]  = mk(1, 7, 7, 0, 0, 0, 32'h77, 32'h88, 1, 0, 0, 32'h0, 0, 0, 1, 32'h77, 32'h88, 0, 1, 1);
        vt[7]  = mk(1, 0, 0, 7, 1, 1, 32'h99, 32'hAA, 1, 0, 0, 32'h0, 0, 0, 1, 32'h99, 32'hAA, 7, 1, 1);
        vt[8]  = mk(1, 7, 7, 9, 1, 1, 32'h1, 32'h2, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        vt[9]  = mk(1, 7, 7, 12, 1, 1, 32'h3, 32'h4, 1, 0, 0, 32'h0, 0, 0, 1, 32'h3, 32'h4, 12, 1, 1);
        vt[10] = mk(0, 12, 12, 5, 1, 1, 32'h5, 32'h6, 0, 0, 0, 32'h0, 0, 0, 0, 32'h5, 32'h6, 5, 0, 1);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", {31'd0, ex_valid}, 32'd0);
        chk("reset.op1", ex_op1, 32'd0);
        chk("reset.cnt", {28'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        // Directed table, one row per clock
        for (int i = 0; i < 11; i++) begin
            drive_vec(vt[i]);
            #4;
            chk($sformatf("vec%0d.stall", i), {31'd0, stall}, {31'd0, vt[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.valid", i), {31'd0, ex_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d.op1", i), ex_op1, vt[i].e_op1);
            chk($sformatf("vec%0d.op2", i), ex_op2, vt[i].e_op2);
            chk($sformatf("vec%0d.rd", i), {27'd0, ex_rd}, {27'd0, vt[i].e_rd});
            chk($sformatf("vec%0d.mr", i), {31'd0, ex_mem_read}, {31'd0, vt[i].e_mr});
            chk($sformatf("vec%0d.rw", i), {31'd0, ex_reg_write}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d.cnt", i), {28'd0, stall_cnt}, {28'd0, vt[i].e_cnt});
        end

        // Asynchronous reset in the middle of a stall
        drive_vec(mk(1, 2, 3, 7, 1, 1, 32'h10, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("prerst.valid", {31'd0, ex_valid}, 32'd1);
        drive_vec(mk(1, 7, 3, 4, 1, 0, 32'h10, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("prerst.stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.valid", {31'd0, ex_valid}, 32'd0);
        chk("rst.mr", {31'd0, ex_mem_read}, 32'd0);
        chk("rst.rd", {27'd0, ex_rd}, 32'd0);
        chk("rst.op1", ex_op1, 32'd0);
        chk("rst.cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst.stall", {31'd0, stall}, 32'd0);
        #2;
        rst_n = 1'b1;
        drive_vec(mk(1, 1, 2, 3, 1, 1, 32'hA1, 32'hB2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("postrst.valid", {31'd0, ex_valid}, 32'd1);
        chk("postrst.rd", {27'd0, ex_rd}, 32'd3);
        chk("postrst.op1", ex_op1, 32'hA1);

        // Saturation: a load that reads its own destination stalls every other cycle
        rst_n = 1'b0;
        idle_inputs();
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 44; i++) begin
            drive_vec(mk(1, 7, 0, 7, 1, 0, 32'h70, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            #4;
            chk("sat.stall", {31'd0, stall}, {31'd0, m_haz() && !flush});
            model_edge();
            @(posedge clk);
            #1;
            compare_all("sat");
        end
        chk("sat.final", {28'd0, stall_cnt}, 32'd15);

        // Randomized traffic against the model
        rst_n = 1'b0;
        idle_inputs();
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            id_valid      = ($urandom_range(0, 3) != 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_rd         = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom);
            id_use_rs2    = 1'($urandom);
            id_rdata1     = $urandom;
            id_rdata2     = $urandom;
            id_imm        = $urandom;
            id_reg_write  = 1'($urandom);
            id_mem_read   = ($urandom_range(0, 2) == 0);
            id_mem_write  = 1'($urandom);
            id_mem_to_reg = 1'($urandom);
            id_alu_src    = 1'($urandom);
            id_branch     = 1'($urandom);
            id_alu_op     = 4'($urandom);
            wb_reg_write  = 1'($urandom);
            wb_rd         = 5'($urandom_range(0, 3));
            wb_data       = $urandom;
            flush         = ($urandom_range(0, 7) == 0);
            #4;
            chk("rand.stall", {31'd0, stall}, {31'd0, m_haz() && !flush});
            model_edge();
            @(posedge clk);
            #1;
            compare_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage sitting between the decode-side register file and the execute stage. Each cycle it latches:
- the two register-file read operands;
- the decoded control bits, register indices and immediate.

It also:
- bypasses a same-cycle write-back into the operands, because the register file has no internal write-through;
- detects load-use hazards, stalling IF/ID and inserting a bubble;
- honours a branch flush and keeps a saturating stall counter.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register index width
ALUOP_W, 4, ALU operation code width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_rs1  in  REG_AW  source index 1 (same as register-file readReg1)
id_rs2  in  REG_AW  source index 2 (same as readReg2)
id_rd  in  REG_AW  destination index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rdata1  in  DATA_W  register-file readData1
id_rdata2  in  DATA_W  register-file readData2
id_imm  in  DATA_W  sign-extended immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  decoded control
id_alu_op  in  ALUOP_W  ALU operation
wb_reg_write  in  1  write-back enable (same as register-file RegWrite)
wb_rd  in  REG_AW  write-back index
wb_data  in  DATA_W  write-back data
flush  in  1  branch taken / redirect; kill the ID instruction
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX holds a real instruction
ex_rs1, ex_rs2, ex_rd  out  REG_AW  latched indices (for EX forwarding)
ex_op1, ex_op2, ex_imm  out  DATA_W  latched operands/immediate
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1 each
ex_alu_op  out  ALUOP_W
stall_cnt  out  CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset, asynchronous on rst_n low: all ex_* outputs 0, ex_valid 0, stall_cnt 0. Reset takes effect immediately, including mid-stall.
- Bypass (combinational):
  - op1 = wb_data when wb_reg_write && wb_rd != 0 && wb_rd == id_rs1; otherwise id_rdata1.
  - op2 uses the same rule against id_rs2.
  - Index 0 is never bypassed.
- Hazard (combinational): haz = id_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2)).
- stall = haz && !flush. A flush takes precedence because the ID instruction is dead anyway.
- Register update on each rising edge, in priority order:
  1. flush: load a bubble. ex_valid = 0, all control bits 0, ex_alu_op 0. Data and index fields are don't-care and are driven 0.
  2. haz: load a bubble as in 1. IF/ID holds the instruction, so it re-presents next cycle, when ex_mem_read of the bubble is 0 and haz clears. The stall lasts exactly 1 cycle.
  3. otherwise: load the ID fields. ex_valid = id_valid, with the bypassed op1/op2.
- Control bits are forced to 0 whenever the loaded ex_valid is 0, so a bubble can never write a register or memory.
- Latency: ID to EX is 1 cycle; stall is same-cycle.
- stall_cnt increments on each edge where stall = 1 and holds at all-ones (saturates).
- Simultaneous events:
  - Bypass and hazard together: the bubble is loaded and the bypassed value is discarded. Still correct, because the held register-file read returns the committed value next cycle.
  - A bypass for rs1 and rs2 may both fire in the same cycle.

Decomposition:
- Shared package: REG_AW, DATA_W and ALUOP_W constants; the ALU-op encodings; the zero-register index constant; the bubble control-vector constant.
- One natural sub-module, id_hazard_detect: the combinational haz/stall logic only. The bypass muxes and pipeline register stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n = 0 mid-operation with ex_valid = 1 -> all ex_* outputs 0 and stall_cnt 0 immediately. After release, the first valid ID instruction appears on the next edge.
- Bypass: id_rs1 = 5, id_rdata1 = 0x11, wb_reg_write = 1, wb_rd = 5, wb_data = 0xDEAD -> ex_op1 = 0xDEAD next edge. Repeat with wb_rd = 0 and id_rs1 = 0 -> ex_op1 = id_rdata1.
- Load-use: EX holds a load (ex_mem_read = 1, ex_rd = 7); ID presents an instruction with use_rs2 = 1 and id_rs2 = 7 -> stall = 1 for one cycle, ex_valid = 0 and stall_cnt = 1. Next edge the instruction enters EX with ex_valid = 1.
- No false hazard: ex_rd = 7 with use_rs1 = use_rs2 = 0, or ex_rd = 0 with rs1 = 0 -> stall stays 0.
- Flush priority: haz and flush together -> stall = 0, bubble loaded, stall_cnt unchanged.
- Saturation: with CNT_W = 4, force 20 stall cycles -> stall_cnt = 15 and holds.
